// File: rtl/multi_cycle_controller_pkg.sv
// Shared types and encodings for the multi-cycle controller: FSM states,
// instruction classes, ALU codes, opcode/funct values and mux selects.
package multi_cycle_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [3:0] {
        CL_ALU,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_BNE,
        CL_J,
        CL_JAL,
        CL_JR,
        CL_ILLEGAL
    } instr_class_e;

    localparam logic [3:0] ALUC_ADDU = 4'b0000;
    localparam logic [3:0] ALUC_SUBU = 4'b0001;
    localparam logic [3:0] ALUC_ADD  = 4'b0010;
    localparam logic [3:0] ALUC_SUB  = 4'b0011;
    localparam logic [3:0] ALUC_AND  = 4'b0100;
    localparam logic [3:0] ALUC_OR   = 4'b0101;
    localparam logic [3:0] ALUC_XOR  = 4'b0110;
    localparam logic [3:0] ALUC_NOR  = 4'b0111;
    localparam logic [3:0] ALUC_LUI  = 4'b1001;
    localparam logic [3:0] ALUC_SLTU = 4'b1010;
    localparam logic [3:0] ALUC_SLT  = 4'b1011;
    localparam logic [3:0] ALUC_SRA  = 4'b1100;
    localparam logic [3:0] ALUC_SRL  = 4'b1101;
    localparam logic [3:0] ALUC_SLL  = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [4:0] EXT_NONE = 5'b00000;
    localparam logic [4:0] EXT1     = 5'b00001;
    localparam logic [4:0] EXT5     = 5'b00010;
    localparam logic [4:0] EXT16    = 5'b00100;
    localparam logic [4:0] EXT16S   = 5'b01000;
    localparam logic [4:0] EXT18S   = 5'b10000;

    localparam logic [1:0] RF_RD   = 2'd0;
    localparam logic [1:0] RF_RT   = 2'd1;
    localparam logic [1:0] RF_LINK = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

    typedef struct packed {
        instr_class_e cls;
        logic [3:0]   aluc;
        logic [4:0]   ext_sel;
        logic         alu_a_sel;
        logic         alu_b_sel;
        logic [1:0]   rf_wsel;
        logic [1:0]   wb_sel;
    } ctrl_t;

    function automatic ctrl_t mk_ctrl(input instr_class_e cls, input logic [3:0] aluc,
                                      input logic [4:0] ext, input logic a_sel,
                                      input logic b_sel, input logic [1:0] rf,
                                      input logic [1:0] wb);
        ctrl_t c;
        c.cls       = cls;
        c.aluc      = aluc;
        c.ext_sel   = ext;
        c.alu_a_sel = a_sel;
        c.alu_b_sel = b_sel;
        c.rf_wsel   = rf;
        c.wb_sel    = wb;
        return c;
    endfunction

endpackage

// File: rtl/multi_cycle_controller_decoder.sv
// Opcode/funct decode into per-instruction class and datapath selects.
// Purely combinational; only the opcode and funct fields are examined.
module instr_decoder
    import multi_cycle_controller_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_unused_fields;

    assign w_op            = i_instr[31:26];
    assign w_fn            = i_instr[5:0];
    assign w_unused_fields = ^i_instr[25:6];

    always_comb begin
        o_ctrl = mk_ctrl(CL_ILLEGAL, ALUC_ADDU, EXT_NONE, 1'b0, 1'b0, RF_RD, WB_ALU);
        if (w_op == OP_RTYPE) begin
            case (w_fn)
                FN_ADD:  o_ctrl = mk_ctrl(CL_ALU, ALUC_ADD,  EXT_NONE, 1'b0, 1'b0, RF_RD, WB_ALU);
                FN_ADDU: o_ctrl = mk_ctrl(CL_ALU, ALUC_ADDU, EXT_NONE, 1'b0, 1'b0, RF_RD, WB_ALU);
                FN_SUB:  o_ctrl = mk_ctrl(CL_ALU, ALUC_SUB,  EXT_NONE, 1'b0, 1'b0, RF_RD, WB_ALU);
                FN_SUBU: o_ctrl = mk_ctrl(CL_ALU, ALUC_SUBU, EXT_NONE, 1'b0, 1'b0, RF_RD, WB_ALU);
                FN_AND:  o_ctrl = mk_ctrl(CL_ALU, ALUC_AND,  EXT_NONE, 1'b0, 1'b0, RF_RD, WB_ALU);
                FN_OR:   o_ctrl = mk_ctrl(CL_ALU, ALUC_OR,   EXT_NONE, 1'b0, 1'b0, RF_RD, WB_ALU);
                FN_XOR:  o_ctrl = mk_ctrl(CL_ALU, ALUC_XOR,  EXT_NONE, 1'b0, 1'b0, RF_RD, WB_ALU);
                FN_NOR:  o_ctrl = mk_ctrl(CL_ALU, ALUC_NOR,  EXT_NONE, 1'b0, 1'b0, RF_RD, WB_ALU);
                FN_SLT:  o_ctrl = mk_ctrl(CL_ALU, ALUC_SLT,  EXT1,     1'b0, 1'b0, RF_RD, WB_ALU);
                FN_SLTU: o_ctrl = mk_ctrl(CL_ALU, ALUC_SLTU, EXT1,     1'b0, 1'b0, RF_RD, WB_ALU);
                FN_SLL:  o_ctrl = mk_ctrl(CL_ALU, ALUC_SLL,  EXT5,     1'b1, 1'b0, RF_RD, WB_ALU);
                FN_SRL:  o_ctrl = mk_ctrl(CL_ALU, ALUC_SRL,  EXT5,     1'b1, 1'b0, RF_RD, WB_ALU);
                FN_SRA:  o_ctrl = mk_ctrl(CL_ALU, ALUC_SRA,  EXT5,     1'b1, 1'b0, RF_RD, WB_ALU);
                FN_SLLV: o_ctrl = mk_ctrl(CL_ALU, ALUC_SLL,  EXT_NONE, 1'b0, 1'b0, RF_RD, WB_ALU);
                FN_SRLV: o_ctrl = mk_ctrl(CL_ALU, ALUC_SRL,  EXT_NONE, 1'b0, 1'b0, RF_RD, WB_ALU);
                FN_SRAV: o_ctrl = mk_ctrl(CL_ALU, ALUC_SRA,  EXT_NONE, 1'b0, 1'b0, RF_RD, WB_ALU);
                FN_JR:   o_ctrl = mk_ctrl(CL_JR,  ALUC_ADDU, EXT_NONE, 1'b0, 1'b0, RF_RD, WB_ALU);
                default: ;
            endcase
        end else begin
            case (w_op)
                OP_ADDI:  o_ctrl = mk_ctrl(CL_ALU, ALUC_ADD,  EXT16S,        1'b0, 1'b1, RF_RT, WB_ALU);
                OP_ADDIU: o_ctrl = mk_ctrl(CL_ALU, ALUC_ADDU, EXT16S,        1'b0, 1'b1, RF_RT, WB_ALU);
                OP_SLTI:  o_ctrl = mk_ctrl(CL_ALU, ALUC_SLT,  EXT16S | EXT1, 1'b0, 1'b1, RF_RT, WB_ALU);
                OP_SLTIU: o_ctrl = mk_ctrl(CL_ALU, ALUC_SLTU, EXT16S | EXT1, 1'b0, 1'b1, RF_RT, WB_ALU);
                OP_ANDI:  o_ctrl = mk_ctrl(CL_ALU, ALUC_AND,  EXT16,         1'b0, 1'b1, RF_RT, WB_ALU);
                OP_ORI:   o_ctrl = mk_ctrl(CL_ALU, ALUC_OR,   EXT16,         1'b0, 1'b1, RF_RT, WB_ALU);
                OP_XORI:  o_ctrl = mk_ctrl(CL_ALU, ALUC_XOR,  EXT16,         1'b0, 1'b1, RF_RT, WB_ALU);
                OP_LUI:   o_ctrl = mk_ctrl(CL_ALU, ALUC_LUI,  EXT16,         1'b0, 1'b1, RF_RT, WB_ALU);
                OP_LW:    o_ctrl = mk_ctrl(CL_LW,  ALUC_ADDU, EXT16S,        1'b0, 1'b1, RF_RT, WB_MEM);
                OP_SW:    o_ctrl = mk_ctrl(CL_SW,  ALUC_ADDU, EXT16S,        1'b0, 1'b1, RF_RT, WB_ALU);
                OP_BEQ:   o_ctrl = mk_ctrl(CL_BEQ, ALUC_SUBU, EXT18S,        1'b0, 1'b0, RF_RD, WB_ALU);
                OP_BNE:   o_ctrl = mk_ctrl(CL_BNE, ALUC_SUBU, EXT18S,        1'b0, 1'b0, RF_RD, WB_ALU);
                OP_J:     o_ctrl = mk_ctrl(CL_J,   ALUC_ADDU, EXT_NONE,      1'b0, 1'b0, RF_RD, WB_ALU);
                OP_JAL:   o_ctrl = mk_ctrl(CL_JAL, ALUC_ADDU, EXT_NONE,      1'b0, 1'b0, RF_LINK, WB_PC);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle CPU controller: FSM, memory wait counter and sticky fault.
// Strobes are decoded from the current state so reset clears them at once.
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 16,
    parameter int JAL_LINK_REG = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        i_or_d,
    output logic        ir_w,
    output logic        pc_w,
    output logic        reg_w,
    output logic [3:0]  aluc,
    output logic [4:0]  ext_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  rf_wsel,
    output logic [1:0]  wb_sel,
    output logic [1:0]  pc_sel,
    output logic        busy,
    output logic [1:0]  fault
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    if (JAL_LINK_REG < 0 || JAL_LINK_REG > 31 || MEM_TIMEOUT < 0) begin : g_bad_param
        $error("multi_cycle_controller: parameter out of range");
    end

    state_e           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [1:0]       r_fault;
    ctrl_t            w_ctrl;
    logic             w_timeout;

    instr_decoder u_decoder (
        .i_instr (instr),
        .o_ctrl  (w_ctrl)
    );

    // The cycle that would be the MEM_TIMEOUT-th wait without mem_ready trips the fault.
    assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_fault    <= FAULT_NONE;
        end else begin
            r_wait_cnt <= '0;
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH, S_MEM: begin
                    if (mem_ready) begin
                        if (r_state == S_FETCH)
                            r_state <= S_DECODE;
                        else if (w_ctrl.cls == CL_LW)
                            r_state <= S_WB;
                        else
                            r_state <= S_FETCH;
                    end else if (w_timeout) begin
                        r_fault <= FAULT_TIMEOUT;
                        r_state <= S_HALT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    case (w_ctrl.cls)
                        CL_J, CL_JAL, CL_JR: r_state <= S_FETCH;
                        CL_ILLEGAL: begin
                            r_fault <= FAULT_ILLEGAL;
                            r_state <= S_HALT;
                        end
                        default: r_state <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (w_ctrl.cls)
                        CL_BEQ, CL_BNE: r_state <= S_FETCH;
                        CL_LW, CL_SW:   r_state <= S_MEM;
                        default:        r_state <= S_WB;
                    endcase
                end
                S_WB:    r_state <= S_FETCH;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        i_or_d    = 1'b0;
        ir_w      = 1'b0;
        pc_w      = 1'b0;
        reg_w     = 1'b0;
        aluc      = 4'b0000;
        ext_sel   = EXT_NONE;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        rf_wsel   = RF_RD;
        wb_sel    = WB_ALU;
        pc_sel    = PC_PLUS4;
        busy      = (r_state != S_IDLE) && (r_state != S_HALT);
        fault     = r_fault;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                i_or_d  = 1'b0;
                if (mem_ready) begin
                    ir_w   = 1'b1;
                    pc_w   = 1'b1;
                    pc_sel = PC_PLUS4;
                end
            end
            S_DECODE: begin
                case (w_ctrl.cls)
                    CL_J: begin
                        pc_w   = 1'b1;
                        pc_sel = PC_JUMP;
                    end
                    CL_JAL: begin
                        pc_w    = 1'b1;
                        pc_sel  = PC_JUMP;
                        reg_w   = 1'b1;
                        rf_wsel = RF_LINK;
                        wb_sel  = WB_PC;
                    end
                    CL_JR: begin
                        pc_w   = 1'b1;
                        pc_sel = PC_RS;
                    end
                    default: ;
                endcase
            end
            S_EXEC, S_MEM: begin
                aluc      = w_ctrl.aluc;
                ext_sel   = w_ctrl.ext_sel;
                alu_a_sel = w_ctrl.alu_a_sel;
                alu_b_sel = w_ctrl.alu_b_sel;
                if (r_state == S_MEM) begin
                    mem_req = 1'b1;
                    i_or_d  = 1'b1;
                    mem_we  = (w_ctrl.cls == CL_SW);
                end else if (w_ctrl.cls == CL_BEQ || w_ctrl.cls == CL_BNE) begin
                    pc_sel = PC_BRANCH;
                    pc_w   = ((w_ctrl.cls == CL_BEQ) && zero) || ((w_ctrl.cls == CL_BNE) && !zero);
                end
            end
            S_WB: begin
                reg_w   = 1'b1;
                rf_wsel = w_ctrl.rf_wsel;
                wb_sel  = w_ctrl.wb_sel;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench: per-instruction expected output traces built from the
// instruction table, applied to the controller cycle by cycle.
module tb_multi_cycle_controller;

    localparam int TMO = 4;
    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4;
    localparam int K_J = 5, K_JAL = 6, K_JR = 7, K_ILL = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, i_or_d, ir_w, pc_w, reg_w;
    logic [3:0]  aluc;
    logic [4:0]  ext_sel;
    logic        alu_a_sel, alu_b_sel;
    logic [1:0]  rf_wsel, wb_sel, pc_sel;
    logic        busy;
    logic [1:0]  fault;

    always #5 clk = ~clk;

    multi_cycle_controller #(.MEM_TIMEOUT(TMO), .JAL_LINK_REG(31)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_w(ir_w), .pc_w(pc_w),
        .reg_w(reg_w), .aluc(aluc), .ext_sel(ext_sel), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .rf_wsel(rf_wsel), .wb_sel(wb_sel), .pc_sel(pc_sel),
        .busy(busy), .fault(fault)
    );

    typedef struct packed {
        logic       mem_req, mem_we, i_or_d, ir_w, pc_w, reg_w;
        logic [3:0] aluc;
        logic [4:0] ext;
        logic       a, b;
        logic [1:0] rf, wb, pcs;
        logic       busy;
        logic [1:0] fault;
    } out_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         kind;
        logic [3:0] aluc;
        logic [4:0] ext;
        logic       a;
        logic       b;
        logic [1:0] rf;
    } vec_t;

    typedef struct {
        logic ready;
        logic real_instr;
        out_t exp;
    } step_t;

    out_t act;
    assign act = {mem_req, mem_we, i_or_d, ir_w, pc_w, reg_w, aluc, ext_sel, alu_a_sel,
                  alu_b_sel, rf_wsel, wb_sel, pc_sel, busy, fault};

    int   n_tests = 0;
    int   n_fail = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input int kind,
                                input logic [3:0] al, input logic [4:0] ext, input logic a,
                                input logic b, input logic [1:0] rf);
        vec_t v;
        v.op = op; v.fn = fn; v.kind = kind; v.aluc = al; v.ext = ext;
        v.a = a; v.b = b; v.rf = rf;
        return v;
    endfunction

    function automatic vec_t lookup(input logic [5:0] op, input logic [5:0] fn);
        foreach (tbl[i])
            if (tbl[i].op == op && (op != 6'h00 || tbl[i].fn == fn)) return tbl[i];
        return mk(op, fn, K_ILL, 4'd0, 5'd0, 1'b0, 1'b0, 2'd0);
    endfunction

    function automatic out_t busy_only();
        out_t o;
        o = '0;
        o.busy = 1'b1;
        return o;
    endfunction

    function automatic out_t alu_view(input vec_t v);
        out_t o;
        o = busy_only();
        o.aluc = v.aluc; o.ext = v.ext; o.a = v.a; o.b = v.b;
        return o;
    endfunction

    task automatic check(input string tag, input out_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (req,we,iod,irw,pcw,rgw,aluc,ext,a,b,rf,wb,pcsel,busy,fault)",
                     tag, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("reset_async_outputs", '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", '0);
        @(posedge clk); #1;
    endtask

    function automatic void push_halt(inout step_t q[$], input logic [1:0] f);
        step_t s;
        s.real_instr = 1'b1;
        s.exp = '0;
        s.exp.fault = f;
        s.ready = 1'b0; q.push_back(s);
        s.ready = 1'b1; q.push_back(s);
    endfunction

    // Expected trace: FETCH waits, then the phases the instruction kind needs.
    task automatic run_instr(input vec_t v, input logic z, input int fdel, input int mdel,
                             input int rst_at, output bit halted);
        step_t       q[$];
        step_t       s;
        out_t        o;
        logic [31:0] word, junk;
        word = $urandom;
        word[31:26] = v.op;
        if (v.op == 6'h00) word[5:0] = v.fn;
        junk = $urandom;
        halted = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            o = busy_only();
            o.mem_req = 1'b1;
            s.ready = (k == fdel);
            s.real_instr = 1'b0;
            if (s.ready) begin o.ir_w = 1'b1; o.pc_w = 1'b1; end
            s.exp = o;
            q.push_back(s);
            if (s.ready) break;
        end
        if (fdel >= TMO) push_halt(q, 2'd2);
        else begin
            o = busy_only();
            s.real_instr = 1'b1;
            s.ready = 1'($urandom_range(0, 1));
            if (v.kind == K_J || v.kind == K_JAL) begin o.pc_w = 1'b1; o.pcs = 2'd2; end
            if (v.kind == K_JAL) begin o.reg_w = 1'b1; o.rf = 2'd2; o.wb = 2'd2; end
            if (v.kind == K_JR) begin o.pc_w = 1'b1; o.pcs = 2'd3; end
            s.exp = o;
            q.push_back(s);
            if (v.kind == K_ILL) push_halt(q, 2'd1);
            else if (v.kind != K_J && v.kind != K_JAL && v.kind != K_JR) begin
                o = alu_view(v);
                s.ready = 1'($urandom_range(0, 1));
                if (v.kind == K_BEQ || v.kind == K_BNE) begin
                    o.pcs = 2'd1;
                    o.pc_w = (v.kind == K_BEQ) ? z : !z;
                end
                s.exp = o;
                q.push_back(s);
                if (v.kind == K_LW || v.kind == K_SW) begin
                    for (int k = 0; k < TMO; k++) begin
                        o = alu_view(v);
                        o.mem_req = 1'b1; o.i_or_d = 1'b1; o.mem_we = (v.kind == K_SW);
                        s.ready = (k == mdel);
                        s.exp = o;
                        q.push_back(s);
                        if (s.ready) break;
                    end
                end
                if ((v.kind == K_LW || v.kind == K_SW) && mdel >= TMO) push_halt(q, 2'd2);
                else if (v.kind == K_LW || v.kind == K_ALU) begin
                    o = busy_only();
                    o.reg_w = 1'b1; o.rf = v.rf; o.wb = (v.kind == K_LW) ? 2'd1 : 2'd0;
                    s.ready = 1'($urandom_range(0, 1));
                    s.exp = o;
                    q.push_back(s);
                end
            end
        end
        zero = z;
        foreach (q[i]) begin
            mem_ready = q[i].ready;
            instr = q[i].real_instr ? word : junk;
            @(negedge clk);
            check($sformatf("op%02h_fn%02h_step%0d", v.op, v.fn, i), q[i].exp);
            if (i == rst_at) begin
                apply_reset();
                mem_ready = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        halted = (q[q.size()-1].exp.busy == 1'b0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   h;
        vec_t v;
        tbl.push_back(mk(6'h00, 6'h20, K_ALU, 4'b0010, 5'b00000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h00, 6'h21, K_ALU, 4'b0000, 5'b00000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h00, 6'h22, K_ALU, 4'b0011, 5'b00000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h00, 6'h23, K_ALU, 4'b0001, 5'b00000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h00, 6'h24, K_ALU, 4'b0100, 5'b00000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h00, 6'h25, K_ALU, 4'b0101, 5'b00000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h00, 6'h26, K_ALU, 4'b0110, 5'b00000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h00, 6'h27, K_ALU, 4'b0111, 5'b00000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h00, 6'h2A, K_ALU, 4'b1011, 5'b00001, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h00, 6'h2B, K_ALU, 4'b1010, 5'b00001, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h00, 6'h00, K_ALU, 4'b1111, 5'b00010, 1'b1, 1'b0, 2'd0));
        tbl.push_back(mk(6'h00, 6'h02, K_ALU, 4'b1101, 5'b00010, 1'b1, 1'b0, 2'd0));
        tbl.push_back(mk(6'h00, 6'h03, K_ALU, 4'b1100, 5'b00010, 1'b1, 1'b0, 2'd0));
        tbl.push_back(mk(6'h00, 6'h04, K_ALU, 4'b1111, 5'b00000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h00, 6'h06, K_ALU, 4'b1101, 5'b00000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h00, 6'h07, K_ALU, 4'b1100, 5'b00000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h00, 6'h08, K_JR,  4'b0000, 5'b00000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h08, 6'h00, K_ALU, 4'b0010, 5'b01000, 1'b0, 1'b1, 2'd1));
        tbl.push_back(mk(6'h09, 6'h00, K_ALU, 4'b0000, 5'b01000, 1'b0, 1'b1, 2'd1));
        tbl.push_back(mk(6'h0A, 6'h00, K_ALU, 4'b1011, 5'b01001, 1'b0, 1'b1, 2'd1));
        tbl.push_back(mk(6'h0B, 6'h00, K_ALU, 4'b1010, 5'b01001, 1'b0, 1'b1, 2'd1));
        tbl.push_back(mk(6'h0C, 6'h00, K_ALU, 4'b0100, 5'b00100, 1'b0, 1'b1, 2'd1));
        tbl.push_back(mk(6'h0D, 6'h00, K_ALU, 4'b0101, 5'b00100, 1'b0, 1'b1, 2'd1));
        tbl.push_back(mk(6'h0E, 6'h00, K_ALU, 4'b0110, 5'b00100, 1'b0, 1'b1, 2'd1));
        tbl.push_back(mk(6'h0F, 6'h00, K_ALU, 4'b1001, 5'b00100, 1'b0, 1'b1, 2'd1));
        tbl.push_back(mk(6'h23, 6'h00, K_LW,  4'b0000, 5'b01000, 1'b0, 1'b1, 2'd1));
        tbl.push_back(mk(6'h2B, 6'h00, K_SW,  4'b0000, 5'b01000, 1'b0, 1'b1, 2'd1));
        tbl.push_back(mk(6'h04, 6'h00, K_BEQ, 4'b0001, 5'b10000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h05, 6'h00, K_BNE, 4'b0001, 5'b10000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h02, 6'h00, K_J,   4'b0000, 5'b00000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h03, 6'h00, K_JAL, 4'b0000, 5'b00000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h3F, 6'h00, K_ILL, 4'b0000, 5'b00000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h01, 6'h00, K_ILL, 4'b0000, 5'b00000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h00, 6'h01, K_ILL, 4'b0000, 5'b00000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(6'h00, 6'h3F, K_ILL, 4'b0000, 5'b00000, 1'b0, 1'b0, 2'd0));

        #2;
        apply_reset();

        run_instr(lookup(6'h00, 6'h21), 1'b0, 0, 0, -1, h);
        run_instr(lookup(6'h23, 6'h00), 1'b0, 1, 3, -1, h);
        run_instr(lookup(6'h04, 6'h00), 1'b1, 0, 0, -1, h);
        run_instr(lookup(6'h04, 6'h00), 1'b0, 0, 0, -1, h);
        run_instr(lookup(6'h05, 6'h00), 1'b1, 2, 0, -1, h);
        run_instr(lookup(6'h05, 6'h00), 1'b0, 0, 0, -1, h);
        run_instr(lookup(6'h03, 6'h00), 1'b0, 3, 0, -1, h);
        run_instr(lookup(6'h00, 6'h21), 1'b0, TMO, 0, -1, h);
        if (h) apply_reset();
        run_instr(lookup(6'h3F, 6'h00), 1'b0, 0, 0, -1, h);
        if (h) apply_reset();
        run_instr(lookup(6'h23, 6'h00), 1'b0, 0, TMO, -1, h);
        if (h) apply_reset();
        run_instr(lookup(6'h2B, 6'h00), 1'b0, 0, 2, 4, h);
        run_instr(lookup(6'h00, 6'h21), 1'b0, 0, 0, -1, h);

        foreach (tbl[i]) begin
            run_instr(tbl[i], 1'(i % 2), i % TMO, (i + 1) % TMO, -1, h);
            if (h) apply_reset();
        end

        repeat (200) begin
            v = tbl[$urandom_range(0, tbl.size() - 1)];
            run_instr(v, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0) ? TMO : int'($urandom_range(0, TMO - 1)),
                      ($urandom_range(0, 7) == 0) ? TMO : int'($urandom_range(0, TMO - 1)),
                      -1, h);
            if (h) apply_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum cycles spent waiting for mem_ready in FETCH or MEM; 0 disables the timeout.
REQ-002 SHALL have parameter JAL_LINK_REG, default 31: destination register for the JAL link write.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 instr  input  32  instruction held in the external IR; valid from DECODE onward.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory completion strobe for the current mem_req.
REQ-008 mem_req  output  1  memory access request.
REQ-009 mem_we  output  1  memory write enable; high only with mem_req.
REQ-010 i_or_d  output  1  memory address source: 0 = PC, 1 = ALU result.
REQ-011 ir_w, pc_w, reg_w  output  1 each  write strobes for IR, PC and RegFile.
REQ-012 aluc  output  4  ALU operation code.
REQ-013 ext_sel  output  5  one-hot extender select: [0] EXT1, [1] EXT5, [2] EXT16, [3] EXT16 signed, [4] EXT18 signed.
REQ-014 alu_a_sel  output  1  0 = rs, 1 = shamt extension.
REQ-015 alu_b_sel  output  1  0 = rt, 1 = extended immediate.
REQ-016 rf_wsel  output  2  write register: 0 = rd, 1 = rt, 2 = JAL_LINK_REG.
REQ-017 wb_sel  output  2  write-back data: 0 = ALU, 1 = memory, 2 = PC.
REQ-018 pc_sel  output  2  next PC: 0 = PC+4, 1 = branch target, 2 = jump concatenation, 3 = rs.
REQ-019 busy  output  1  high in every state except IDLE and HALT.
REQ-020 fault  output  2  sticky fault code: 0 = none, 1 = illegal instruction, 2 = memory timeout.

Function
REQ-021 The FSM SHALL use the states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-022 IDLE SHALL drive all strobes to 0 and move unconditionally to FETCH on the next cycle.
REQ-023 FETCH SHALL drive mem_req=1 and i_or_d=0 while waiting for mem_ready.
REQ-024 On mem_ready in FETCH, the block SHALL pulse ir_w=1 and pc_w=1 with pc_sel=0 for one cycle, then move to DECODE.
REQ-025 DECODE SHALL handle the 31-instruction set (R-type ALU/shift ops, JR, I-type ALU ops, LW, SW, BEQ, BNE, LUI, J, JAL).
REQ-026 In DECODE, J SHALL assert pc_w with pc_sel=2 and go to FETCH.
REQ-027 In DECODE, JAL SHALL additionally assert reg_w with rf_wsel=2 and wb_sel=2; the PC already holds PC+4.
REQ-028 In DECODE, JR SHALL assert pc_w with pc_sel=3 and go to FETCH.
REQ-029 In DECODE, an unrecognised opcode/funct SHALL set fault=1 and go to HALT with no strobe asserted.
REQ-030 All other instructions SHALL move from DECODE to EXEC.
REQ-031 EXEC SHALL drive aluc, ext_sel and the ALU operand selects for the decoded instruction.
REQ-032 In EXEC, BEQ and BNE SHALL use aluc=0001 and ext_sel[4], and assert pc_w with pc_sel=1 only if (BEQ & zero) | (BNE & ~zero); both then go to FETCH.
REQ-033 In EXEC, LW and SW SHALL go to MEM; all other instructions SHALL go to WB.
REQ-034 MEM SHALL drive mem_req=1, i_or_d=1 and mem_we=SW, holding ALU selects as in EXEC.
REQ-035 On mem_ready in MEM, SW SHALL go to FETCH and LW SHALL go to WB.
REQ-036 WB SHALL assert reg_w for exactly one cycle (rf_wsel rd for R-type, rt for I-type; wb_sel 1 for LW, 0 otherwise), then go to FETCH.
REQ-037 aluc codes SHALL be: ADDU 0000, SUBU 0001, ADD 0010, SUB 0011, AND 0100, OR 0101, XOR 0110, NOR 0111, LUI 1001, SLTU 1010, SLT 1011, SRA/SRAV 1100, SRL/SRLV 1101, SLL/SLLV 1111; I-type ops SHALL use their R-type counterpart's code; LW/SW SHALL use 0000.
REQ-038 ext_sel encoding: EXT5 for SLL/SRL/SRA; EXT16 for ANDI/ORI/XORI/LUI; EXT16 signed for ADDI/ADDIU/LW/SW/SLTI/SLTIU; EXT1 additionally for SLT/SLTU/SLTI/SLTIU.
REQ-039 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle without mem_ready.
REQ-040 When the wait counter reaches MEM_TIMEOUT (if nonzero), the block SHALL set fault=2 and go to HALT.
REQ-041 mem_ready arriving on the same cycle the counter reaches the limit SHALL take priority and complete the access normally.
REQ-042 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-043 HALT SHALL be terminal until reset: all strobes 0, busy=0, fault held.
REQ-044 Every instruction latency SHALL be fixed apart from memory waits: J/JR/JAL 2 cycles, branch 3, ALU 4, SW 4, LW 5, each plus wait cycles.

Reset
REQ-045 rst_n low SHALL immediately force state=IDLE, wait counter=0 and fault=0, with all outputs 0, including mid-access.
REQ-046 On release of rst_n, the block SHALL spend one cycle in IDLE, then enter FETCH.

Structure
REQ-047 A shared package SHALL hold the state enum, the aluc code constants, the opcode/funct constants and the sel encodings.
REQ-048 The opcode/funct to per-instruction control decode SHALL be a separate sub-module, instr_decoder.
REQ-049 The FSM, the wait counter and the fault register SHALL stay in multi_cycle_controller.

Verification
REQ-050 ADDU $3,$1,$2 with mem_ready on the first FETCH cycle -> IDLE,FETCH,DECODE,EXEC,WB; aluc=0000, reg_w=1 in WB only, rf_wsel=0.
REQ-051 LW with mem_ready delayed 3 cycles in MEM -> mem_req high 4 cycles with i_or_d=1; WB has wb_sel=1, rf_wsel=1.
REQ-052 BEQ with zero=1, then with zero=0 -> pc_w=1, pc_sel=1 in EXEC for the first case; pc_w=0 for the second.
REQ-053 JAL -> in DECODE pc_w=1, pc_sel=2, reg_w=1, rf_wsel=2, wb_sel=2; next state FETCH.
REQ-054 MEM_TIMEOUT=4 with mem_ready never asserted in FETCH -> HALT after 4 wait cycles, fault=2, busy=0; an illegal opcode 6'h3F instead gives fault=1.
REQ-055 rst_n pulsed low mid-MEM of an SW -> mem_req and mem_we drop the same cycle; restart at IDLE with fault=0.
